// File: rtl/main_fsm_pkg.sv
// Shared types and select encodings for the multicycle main decoder FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MUL,
        S_MUL_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BASE_WB,
        S_BRANCH,
        S_BX
    } state_t;

    // Instruction class produced by the classifier and consumed in DECODE.
    typedef enum logic [2:0] {
        CLS_UNDEF,
        CLS_DP_R,
        CLS_DP_I,
        CLS_MUL,
        CLS_MEM,
        CLS_BR,
        CLS_BX
    } instr_cls_t;

    // Full control word driven towards the datapath.
    typedef struct packed {
        logic       ir_w;
        logic       pc_w;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       alu_op;
        logic       mem_w;
        logic       reg_w3;
        logic       reg_w1;
        logic       post_idx;
        logic       mult;
        logic       busy;
    } ctrl_t;

    localparam logic [1:0] SRC_A_REG    = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_ALUOUT = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_RDATA    = 2'b01;
    localparam logic [1:0] RES_ALU      = 2'b10;

    localparam logic [1:0] IMM_DP       = 2'b00;
    localparam logic [1:0] IMM_MEM      = 2'b01;
    localparam logic [1:0] IMM_BR       = 2'b10;

    localparam logic [1:0] OP_DP        = 2'b00;
    localparam logic [1:0] OP_MEM       = 2'b01;
    localparam logic [1:0] OP_BR        = 2'b10;

    localparam logic [5:0] BX_FUNCT     = 6'b010010;
    localparam logic [3:0] BX_INSTR74   = 4'b0001;
    localparam logic [3:0] MUL_INSTR74  = 4'b1001;

endpackage

// File: rtl/instr_classifier.sv
// Combinational IR field classifier (class, BL link flag, long-multiply write); LONG_MUL_EN enables 64-bit MUL.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; IR fields are assumed stable after FETCH.
module instr_classifier
    import main_fsm_pkg::*;
(
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] instr74,
    output instr_cls_t cls,
    output logic       link,
    output logic       mul_long
);

    // Priority decode: BX, then multiply, then plain data-processing.
    always_comb begin
        cls = CLS_UNDEF;
        if (op == OP_DP) begin
            if (funct == BX_FUNCT && instr74 == BX_INSTR74) begin
                cls = CLS_BX;
            end else if (instr74 == MUL_INSTR74 && !funct[5]) begin
`ifdef LONG_MUL_EN
                cls = CLS_MUL;
`else
                cls = funct[3] ? CLS_UNDEF : CLS_MUL;
`endif
            end else begin
                cls = funct[5] ? CLS_DP_I : CLS_DP_R;
            end
        end else if (op == OP_MEM) begin
            cls = CLS_MEM;
        end else if (op == OP_BR) begin
            cls = CLS_BR;
        end
    end

    assign link = funct[4];

`ifdef LONG_MUL_EN
    assign mul_long = funct[3];
`else
    assign mul_long = 1'b0;
`endif

endmodule

// File: rtl/main_fsm_decoder.sv
// Multicycle Moore main decoder: fetch/decode/execute/memory/writeback sequencing; LONG_MUL_EN enables 64-bit MUL writeback.
// Latency: 2..N cycles per instruction (MUL_CYCLES in MUL, memory states wait on mem_ready).
// Backpressure: FETCH, MEM_RD and MEM_WR hold until mem_ready (ignored when MEM_WAIT=0).
module main_fsm_decoder
    import main_fsm_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int MEM_WAIT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] instr74,
    input  logic       mem_ready,
    output logic       ir_w,
    output logic       pc_w,
    output logic       branch,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic       alu_op,
    output logic       mem_w,
    output logic       reg_w3,
    output logic       reg_w1,
    output logic       post_idx,
    output logic       mult,
    output logic       busy
);

    localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] mul_cnt;
    logic [CNT_W-1:0] mul_cnt_nxt;
    instr_cls_t       cls;
    logic             link;
    logic             mul_long;
    logic             rdy;
    logic             base_wb;
    ctrl_t            ctrl;

    assign rdy     = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    // Base register update needed for post-indexed or writeback forms.
    assign base_wb = !funct[4] || funct[1];

    instr_classifier u_cls (
        .op       (op),
        .funct    (funct),
        .instr74  (instr74),
        .cls      (cls),
        .link     (link),
        .mul_long (mul_long)
    );

    // State and multiply counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            mul_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        case (state)
            S_FETCH:   if (rdy) state_nxt = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_BX:   state_nxt = S_BX;
                    CLS_MUL:  state_nxt = S_MUL;
                    CLS_DP_R: state_nxt = S_EXEC_R;
                    CLS_DP_I: state_nxt = S_EXEC_I;
                    CLS_MEM:  state_nxt = S_MEM_ADR;
                    CLS_BR:   state_nxt = S_BRANCH;
                    default:  state_nxt = S_FETCH;
                endcase
            end
            S_EXEC_R,
            S_EXEC_I:  state_nxt = S_ALU_WB;
            S_MUL: begin
                if (mul_cnt == CNT_LAST) begin
                    state_nxt   = S_MUL_WB;
                    mul_cnt_nxt = '0;
                end else begin
                    mul_cnt_nxt = mul_cnt + 1'b1;
                end
            end
            S_MEM_ADR: state_nxt = funct[0] ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (rdy) state_nxt = S_MEM_WB;
            S_MEM_WB:  state_nxt = base_wb ? S_BASE_WB : S_FETCH;
            S_MEM_WR:  if (rdy) state_nxt = base_wb ? S_BASE_WB : S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Moore control word; everything forced low while reset is held.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            ctrl.busy = (state != S_FETCH);
            case (state)
                S_FETCH: begin
                    ctrl.ir_w       = rdy;
                    ctrl.pc_w       = rdy;
                    ctrl.alu_src_a  = SRC_A_PC;
                    ctrl.alu_src_b  = SRC_B_FOUR;
                    ctrl.result_src = RES_ALU;
                end
                S_DECODE: begin
                    ctrl.alu_src_a  = SRC_A_PC;
                    ctrl.alu_src_b  = SRC_B_FOUR;
                    ctrl.result_src = RES_ALU;
                end
                S_EXEC_R: begin
                    ctrl.alu_op    = 1'b1;
                    ctrl.alu_src_b = SRC_B_REG;
                end
                S_EXEC_I: begin
                    ctrl.alu_op    = 1'b1;
                    ctrl.alu_src_b = SRC_B_IMM;
                end
                S_ALU_WB: begin
                    ctrl.reg_w3     = 1'b1;
                    ctrl.result_src = RES_ALUOUT;
                end
                S_MUL:     ctrl.mult = 1'b1;
                S_MUL_WB: begin
                    ctrl.mult       = 1'b1;
                    ctrl.result_src = RES_ALUOUT;
                    ctrl.reg_w1     = 1'b1;
                    ctrl.reg_w3     = mul_long;
                end
                S_MEM_ADR: begin
                    ctrl.alu_src_b = funct[5] ? SRC_B_REG : SRC_B_IMM;
                    ctrl.imm_src   = IMM_MEM;
                    ctrl.post_idx  = !funct[4];
                end
                S_MEM_RD: begin
                    ctrl.adr_src  = 1'b1;
                    ctrl.post_idx = !funct[4];
                end
                S_MEM_WB: begin
                    ctrl.reg_w3     = 1'b1;
                    ctrl.result_src = RES_RDATA;
                end
                S_MEM_WR: begin
                    ctrl.adr_src  = 1'b1;
                    ctrl.mem_w    = 1'b1;
                    ctrl.post_idx = !funct[4];
                end
                S_BASE_WB: begin
                    ctrl.reg_w1     = 1'b1;
                    ctrl.result_src = RES_ALUOUT;
                end
                S_BRANCH: begin
                    ctrl.branch     = 1'b1;
                    ctrl.alu_src_b  = SRC_B_IMM;
                    ctrl.imm_src    = IMM_BR;
                    ctrl.result_src = RES_ALU;
                    ctrl.reg_src    = link ? 2'b11 : 2'b01;
                    ctrl.reg_w3     = link;
                end
                S_BX: begin
                    ctrl.branch     = 1'b1;
                    ctrl.alu_src_a  = SRC_A_REG;
                    ctrl.alu_src_b  = SRC_B_REG;
                    ctrl.result_src = RES_ALU;
                end
                default: ;
            endcase
        end
    end

    assign ir_w       = ctrl.ir_w;
    assign pc_w       = ctrl.pc_w;
    assign branch     = ctrl.branch;
    assign adr_src    = ctrl.adr_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign result_src = ctrl.result_src;
    assign imm_src    = ctrl.imm_src;
    assign reg_src    = ctrl.reg_src;
    assign alu_op     = ctrl.alu_op;
    assign mem_w      = ctrl.mem_w;
    assign reg_w3     = ctrl.reg_w3;
    assign reg_w1     = ctrl.reg_w1;
    assign post_idx   = ctrl.post_idx;
    assign mult       = ctrl.mult;
    assign busy       = ctrl.busy;

endmodule

// File: tb/tb_main_fsm_decoder.sv
// Bench for main_fsm_decoder: per-cycle output trace model plus literal per-instruction tallies.
// Latency: n/a.
// Backpressure: mem_ready schedule driven per instruction.
module tb_main_fsm_decoder;

    localparam int MUL_CYCLES = 3;
`ifdef LONG_MUL_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    typedef struct packed {
        logic       ir_w;
        logic       pc_w;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       alu_op;
        logic       mem_w;
        logic       reg_w3;
        logic       reg_w1;
        logic       post_idx;
        logic       mult;
        logic       busy;
    } rec_t;

    typedef struct packed {
        int steps;
        int w3;
        int w1;
        int mult;
        int memw;
    } chk_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] instr74;
    logic       mem_ready;
    logic       ir_w, pc_w, branch, adr_src, alu_op, mem_w, reg_w3, reg_w1, post_idx, mult, busy;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
    rec_t       dut_rec;

    rec_t  exp_q[$];
    chk_t  chk_q[$];
    string chk_name_q[$];
    string cur_name = "reset";

    int tests = 0;
    int fails = 0;
    int n_steps = 0, n_w3 = 0, n_w1 = 0, n_mult = 0, n_memw = 0;

    main_fsm_decoder #(.MUL_CYCLES(MUL_CYCLES), .MEM_WAIT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .instr74    (instr74),
        .mem_ready  (mem_ready),
        .ir_w       (ir_w),
        .pc_w       (pc_w),
        .branch     (branch),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .alu_op     (alu_op),
        .mem_w      (mem_w),
        .reg_w3     (reg_w3),
        .reg_w1     (reg_w1),
        .post_idx   (post_idx),
        .mult       (mult),
        .busy       (busy)
    );

    assign dut_rec = {ir_w, pc_w, branch, adr_src, alu_src_a, alu_src_b, result_src,
                      imm_src, reg_src, alu_op, mem_w, reg_w3, reg_w1, post_idx, mult, busy};

    initial forever #5 clk = ~clk;

    task automatic check_cnt(input string nm, input string what, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s %s: got %0d want %0d", nm, what, got, want);
        end
    endtask

    // Single compare process: tallies first, then the per-cycle trace.
    always @(negedge clk) begin
        chk_t  c;
        rec_t  e;
        string nm;
        if (chk_q.size() > 0) begin
            c  = chk_q.pop_front();
            nm = chk_name_q.pop_front();
            check_cnt(nm, "cycles", n_steps, c.steps);
            check_cnt(nm, "reg_w3_cycles", n_w3, c.w3);
            check_cnt(nm, "reg_w1_cycles", n_w1, c.w1);
            check_cnt(nm, "mult_cycles", n_mult, c.mult);
            check_cnt(nm, "mem_w_cycles", n_memw, c.memw);
            n_steps = 0; n_w3 = 0; n_w1 = 0; n_mult = 0; n_memw = 0;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (dut_rec !== e) begin
                fails++;
                $display("FAIL outputs %s @%0t: got %h want %h", cur_name, $time, dut_rec, e);
            end
            n_steps++;
            if (dut_rec.reg_w3) n_w3++;
            if (dut_rec.reg_w1) n_w1++;
            if (dut_rec.mult)   n_mult++;
            if (dut_rec.mem_w)  n_memw++;
        end
    end

    // One clock cycle: drive mem_ready, queue the expected outputs, advance.
    task automatic step(input rec_t r, input logic rdy);
        mem_ready = rdy;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t r_decode();
        rec_t r = '0;
        r.busy = 1'b1; r.alu_src_a = 2'b01; r.alu_src_b = 2'b10; r.result_src = 2'b10;
        return r;
    endfunction

    function automatic rec_t r_mul();
        rec_t r = '0;
        r.busy = 1'b1; r.mult = 1'b1;
        return r;
    endfunction

    // Fetch holds for 'waits' cycles with memory not ready, then completes.
    task automatic do_fetch(input int waits);
        rec_t r;
        logic rdy;
        for (int w = 0; w <= waits; w++) begin
            rdy = (w == waits);
            r = '0;
            r.alu_src_a = 2'b01; r.alu_src_b = 2'b10; r.result_src = 2'b10;
            r.ir_w = rdy; r.pc_w = rdy;
            step(r, rdy);
        end
    endtask

    // Everything after fetch, derived from the architectural meaning of the instruction.
    task automatic do_body(input logic [1:0] o, input logic [5:0] f, input logic [3:0] i74, input int mw);
        rec_t r;
        bit   is_bx, is_mul, is_long;
        step(r_decode(), 1'b1);
        is_bx   = (o == 2'b00) && (f == 6'b010010) && (i74 == 4'b0001);
        is_mul  = (o == 2'b00) && (i74 == 4'b1001) && !f[5];
        is_long = f[3];
        if (o == 2'b11) return;
        if (is_bx) begin
            r = '0; r.busy = 1'b1; r.branch = 1'b1; r.result_src = 2'b10;
            step(r, 1'b1);
        end else if (is_mul) begin
            if (is_long && !LONG_EN) return;
            for (int k = 0; k < MUL_CYCLES; k++) step(r_mul(), 1'b1);
            r = r_mul(); r.reg_w1 = 1'b1; r.reg_w3 = is_long;
            step(r, 1'b1);
        end else if (o == 2'b00) begin
            r = '0; r.busy = 1'b1; r.alu_op = 1'b1; r.alu_src_b = f[5] ? 2'b01 : 2'b00;
            step(r, 1'b1);
            r = '0; r.busy = 1'b1; r.reg_w3 = 1'b1;
            step(r, 1'b1);
        end else if (o == 2'b01) begin
            r = '0; r.busy = 1'b1; r.imm_src = 2'b01; r.post_idx = !f[4];
            r.alu_src_b = f[5] ? 2'b00 : 2'b01;
            step(r, 1'b1);
            r = '0; r.busy = 1'b1; r.adr_src = 1'b1; r.post_idx = !f[4]; r.mem_w = !f[0];
            for (int w = 0; w < mw; w++) step(r, 1'b0);
            step(r, 1'b1);
            if (f[0]) begin
                r = '0; r.busy = 1'b1; r.reg_w3 = 1'b1; r.result_src = 2'b01;
                step(r, 1'b1);
            end
            if (!f[4] || f[1]) begin
                r = '0; r.busy = 1'b1; r.reg_w1 = 1'b1;
                step(r, 1'b1);
            end
        end else begin
            r = '0; r.busy = 1'b1; r.branch = 1'b1; r.alu_src_b = 2'b01; r.imm_src = 2'b10;
            r.result_src = 2'b10; r.reg_src = f[4] ? 2'b11 : 2'b01; r.reg_w3 = f[4];
            step(r, 1'b1);
        end
    endtask

    task automatic push_chk(input string nm, input int s, input int w3, input int w1, input int m, input int mw);
        chk_t c;
        c.steps = s; c.w3 = w3; c.w1 = w1; c.mult = m; c.memw = mw;
        chk_q.push_back(c);
        chk_name_q.push_back(nm);
    endtask

    task automatic set_ir(input string nm, input logic [1:0] o, input logic [5:0] f, input logic [3:0] i74);
        cur_name = nm; op = o; funct = f; instr74 = i74;
    endtask

    task automatic run_instr(input string nm, input logic [1:0] o, input logic [5:0] f, input logic [3:0] i74,
                             input int fw, input int mw,
                             input int s, input int w3, input int w1, input int m, input int memw);
        set_ir(nm, o, f, i74);
        do_fetch(fw);
        do_body(o, f, i74, mw);
        push_chk(nm, s, w3, w1, m, memw);
    endtask

    // Two cycles in reset (memory ready toggling must not leak through), then release.
    task automatic reset_pulse();
        reset = 1'b1;
        step('0, 1'b1);
        step('0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        rec_t r;
        reset = 1'b1; op = '0; funct = '0; instr74 = '0; mem_ready = 1'b0;
        @(posedge clk); #1;
        step('0, 1'b1);
        reset = 1'b0;
        push_chk("reset", 1, 0, 0, 0, 0);

        //         name            op     funct      i74   fw mw  cyc w3 w1 mult memw
        run_instr("add_reg",     2'b00, 6'b000000, 4'b0001, 0, 0,  4, 1, 0, 0, 0);
        run_instr("add_fwait",   2'b00, 6'b000000, 4'b0001, 2, 0,  6, 1, 0, 0, 0);
        run_instr("dp_imm",      2'b00, 6'b101000, 4'b0000, 0, 0,  4, 1, 0, 0, 0);
        run_instr("ldr_post",    2'b01, 6'b000001, 4'b0000, 0, 2,  8, 1, 1, 0, 0);
        run_instr("str_pre",     2'b01, 6'b110000, 4'b0000, 0, 0,  4, 0, 0, 0, 1);
        run_instr("str_wb_wait", 2'b01, 6'b010010, 4'b0000, 0, 1,  6, 0, 1, 0, 2);
        run_instr("ldr_pre",     2'b01, 6'b110001, 4'b0000, 0, 0,  5, 1, 0, 0, 0);
        run_instr("mul",         2'b00, 6'b000000, 4'b1001, 0, 0,  6, 0, 1, 4, 0);
        run_instr("mul_long",    2'b00, 6'b001000, 4'b1001, 0, 0,
                  LONG_EN ? 6 : 2, LONG_EN ? 1 : 0, LONG_EN ? 1 : 0, LONG_EN ? 4 : 0, 0);
        run_instr("bl",          2'b10, 6'b110000, 4'b0000, 0, 0,  3, 1, 0, 0, 0);
        run_instr("b",           2'b10, 6'b100000, 4'b0000, 0, 0,  3, 0, 0, 0, 0);
        run_instr("bx",          2'b00, 6'b010010, 4'b0001, 0, 0,  3, 0, 0, 0, 0);
        run_instr("undef",       2'b11, 6'b000000, 4'b0000, 0, 0,  2, 0, 0, 0, 0);

        // Reset while a store waits on memory, then rerun the store to completion.
        set_ir("str_reset", 2'b01, 6'b110000, 4'b0000);
        do_fetch(0);
        step(r_decode(), 1'b1);
        r = '0; r.busy = 1'b1; r.imm_src = 2'b01;
        step(r, 1'b1);
        r = '0; r.busy = 1'b1; r.adr_src = 1'b1; r.mem_w = 1'b1;
        step(r, 1'b0);
        reset_pulse();
        do_fetch(1);
        do_body(2'b01, 6'b110000, 4'b0000, 0);
        push_chk("str_reset", 11, 0, 0, 0, 2);

        // Reset partway through the multiply; the cycle counter must restart.
        set_ir("mul_reset", 2'b00, 6'b000000, 4'b1001);
        do_fetch(0);
        step(r_decode(), 1'b1);
        step(r_mul(), 1'b1);
        step(r_mul(), 1'b1);
        reset_pulse();
        do_fetch(0);
        do_body(2'b00, 6'b000000, 4'b1001, 0);
        push_chk("mul_reset", 12, 0, 1, 6, 0);

        run_instr("add_last",    2'b00, 6'b000000, 4'b0001, 0, 0,  4, 1, 0, 0, 0);

        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
